player_life_manager: RTL and testbench

Tracks the player's lives, death animation, respawn and post-respawn invulnerability for the gameplay loop. Consumes the 2-bit game-state code produced by the top-level game FSM and returns the `playerDead` level that drives that FSM into Game Over. Sits between the collision logic (hit source), the frame timing (vsync tick) and the sprite/HUD renderers.

---
 rtl/game_pkg.sv | 28 ++
 rtl/player_life_manager_if.sv | 27 ++
 rtl/player_life_manager_timer.sv | 56 +++++
 rtl/player_life_manager.sv | 109 ++++++++++
 tb/tb_player_life_manager.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared gameplay definitions: game-state codes from the top-level game FSM,
// the player life FSM state encoding and the width of the lives counter.
// Also holds the sprite blink helper used while the player is invulnerable.
package game_pkg;

  localparam logic [1:0] GS_START    = 2'b00;
  localparam logic [1:0] GS_PLAY     = 2'b01;
  localparam logic [1:0] GS_GAMEOVER = 2'b10;

  localparam int LIVES_W   = 3;
  // Elapsed-frame counter only needs to cover one blink period (8 frames).
  localparam int ELAPSED_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SPAWN  = 3'd1,
    ST_INVULN = 3'd2,
    ST_ALIVE  = 3'd3,
    ST_DYING  = 3'd4,
    ST_DEAD   = 3'd5
  } life_state_e;

  // Sprite is shown for frames 0..3 of every 8-frame period, hidden for 4..7.
  function automatic logic blink_visible(input logic [ELAPSED_W-1:0] elapsed);
    return (elapsed < 3'd4);
  endfunction

endpackage

// File: rtl/player_life_manager_if.sv
// Bundle between the game side (game FSM, frame timing, collision logic,
// renderers) and the player life manager.
//   master: drives gameState/frameTick/hit, observes the player status.
//   slave : the life manager itself.
interface player_life_manager_if;
  import game_pkg::*;

  logic [1:0]         gameState;
  logic               frameTick;
  logic               hit;
  logic               playerDead;
  logic [LIVES_W-1:0] lives;
  logic               dying;
  logic               respawn;
  logic               invulnerable;
  logic               playerVisible;

  modport master (
    output gameState, frameTick, hit,
    input  playerDead, lives, dying, respawn, invulnerable, playerVisible
  );

  modport slave (
    input  gameState, frameTick, hit,
    output playerDead, lives, dying, respawn, invulnerable, playerVisible
  );
endinterface

// File: rtl/player_life_manager_timer.sv
// Loadable frame down-counter shared by the death animation and the
// invulnerability window.
//   Clk, Reset     : clock, synchronous active-high reset
//   load_i         : load count with load_value_i and clear elapsed count
//   load_value_i   : number of frame ticks to count
//   frame_tick_i   : one-cycle pulse per video frame
//   expire_o       : tick arriving while count is 1 (last frame of the window)
//   elapsed_o      : frames counted since the last load (wraps, used for blink)
module frame_timer
  import game_pkg::*;
#(
  parameter int unsigned TIMER_W = 7
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 load_i,
  input  logic [TIMER_W-1:0]   load_value_i,
  input  logic                 frame_tick_i,
  output logic                 expire_o,
  output logic [ELAPSED_W-1:0] elapsed_o
);

  logic [TIMER_W-1:0]   count_q,   count_d;
  logic [ELAPSED_W-1:0] elapsed_q, elapsed_d;

  // Next count: load wins over a tick; an idle counter at zero stays put.
  always_comb begin
    count_d   = count_q;
    elapsed_d = elapsed_q;
    if (load_i) begin
      count_d   = load_value_i;
      elapsed_d = {ELAPSED_W{1'b0}};
    end else if (frame_tick_i && (count_q != {TIMER_W{1'b0}})) begin
      count_d   = count_q - {{(TIMER_W-1){1'b0}}, 1'b1};
      elapsed_d = elapsed_q + {{(ELAPSED_W-1){1'b0}}, 1'b1};
    end else begin
      count_d   = count_q;
      elapsed_d = elapsed_q;
    end
  end

  // Counter registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q   <= {TIMER_W{1'b0}};
      elapsed_q <= {ELAPSED_W{1'b0}};
    end else begin
      count_q   <= count_d;
      elapsed_q <= elapsed_d;
    end
  end

  assign expire_o  = frame_tick_i && (count_q == {{(TIMER_W-1){1'b0}}, 1'b1});
  assign elapsed_o = elapsed_q;

endmodule

// File: rtl/player_life_manager.sv
// Player life FSM: lives, death animation, respawn and post-spawn
// invulnerability. Outputs are decoded from the registered state only.
//   Clk, Reset : clock, synchronous active-high reset
//   bus        : slave side of player_life_manager_if
//                in : gameState, frameTick, hit
//                out: playerDead, lives, dying, respawn, invulnerable,
//                     playerVisible
module player_life_manager
  import game_pkg::*;
#(
  parameter int unsigned LIVES         = 3,
  parameter int unsigned DEATH_FRAMES  = 60,
  parameter int unsigned INVULN_FRAMES = 120
) (
  input  logic                  Clk,
  input  logic                  Reset,
  player_life_manager_if.slave  bus
);

  localparam int unsigned MAX_FRAMES =
    (DEATH_FRAMES > INVULN_FRAMES) ? DEATH_FRAMES : INVULN_FRAMES;
  localparam int unsigned TIMER_W = $clog2(MAX_FRAMES + 1);

  life_state_e          state_q, state_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic                 load_s;
  logic [TIMER_W-1:0]   load_value_s;
  logic                 expire_s;
  logic [ELAPSED_W-1:0] elapsed_s;

  frame_timer #(.TIMER_W(TIMER_W)) u_timer (
    .Clk          (Clk),
    .Reset        (Reset),
    .load_i       (load_s),
    .load_value_i (load_value_s),
    .frame_tick_i (bus.frameTick),
    .expire_o     (expire_s),
    .elapsed_o    (elapsed_s)
  );

  // Next-state, lives update and timer load; leaving Play overrides all.
  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    load_s       = 1'b0;
    load_value_s = {TIMER_W{1'b0}};
    if (bus.gameState != GS_PLAY) begin
      // lives is kept so the Game Over screen can still show it
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SPAWN;
          lives_d = LIVES_W'(LIVES);
        end
        ST_SPAWN: begin
          state_d      = ST_INVULN;
          load_s       = 1'b1;
          load_value_s = TIMER_W'(INVULN_FRAMES);
        end
        ST_INVULN: begin
          if (expire_s) state_d = ST_ALIVE;
          else          state_d = ST_INVULN;
        end
        ST_ALIVE: begin
          // ALIVE is only reachable with lives >= 1, so no underflow here
          if (bus.hit) begin
            state_d      = ST_DYING;
            lives_d      = lives_q - 3'd1;
            load_s       = 1'b1;
            load_value_s = TIMER_W'(DEATH_FRAMES);
          end else begin
            state_d = ST_ALIVE;
          end
        end
        ST_DYING: begin
          if (expire_s) begin
            if (lives_q == 3'd0) state_d = ST_DEAD;
            else                 state_d = ST_SPAWN;
          end else begin
            state_d = ST_DYING;
          end
        end
        ST_DEAD:  state_d = ST_DEAD;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // State and lives registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      lives_q <= 3'd0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
    end
  end

  assign bus.playerDead    = (state_q == ST_DEAD);
  assign bus.dying         = (state_q == ST_DYING);
  assign bus.respawn       = (state_q == ST_SPAWN);
  assign bus.invulnerable  = (state_q == ST_SPAWN) || (state_q == ST_INVULN);
  assign bus.playerVisible = (state_q == ST_INVULN) ? blink_visible(elapsed_s)
                           : !((state_q == ST_IDLE) || (state_q == ST_DEAD));
  assign bus.lives         = lives_q;

endmodule

// File: tb/tb_player_life_manager.sv
// Bench for player_life_manager: a vector table (inputs + expected outputs)
// replayed through a scoreboard queue, then hand-written blink and
// mid-sequence reset sequences. dut1 uses INVULN_FRAMES=4, dut2 uses 16.
module tb_player_life_manager;

  typedef struct packed {
    logic       dead;
    logic [2:0] lives;
    logic       dying;
    logic       respawn;
    logic       inv;
    logic       vis;
  } out_t;

  typedef struct {
    logic [1:0] gs;
    logic       tick;
    logic       hit;
    out_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] gs = 2'b00;
  logic       tick = 1'b0;
  logic       hit = 1'b0;

  int total = 0;
  int bad   = 0;

  out_t q1[$];
  out_t q2[$];
  vec_t tbl[$];

  player_life_manager_if if1 ();
  player_life_manager_if if2 ();

  assign if1.gameState = gs;
  assign if1.frameTick = tick;
  assign if1.hit       = hit;
  assign if2.gameState = gs;
  assign if2.frameTick = tick;
  assign if2.hit       = hit;

  player_life_manager #(.LIVES(2), .DEATH_FRAMES(3), .INVULN_FRAMES(4)) dut1 (
    .Clk(clk), .Reset(rst), .bus(if1)
  );

  player_life_manager #(.LIVES(2), .DEATH_FRAMES(3), .INVULN_FRAMES(16)) dut2 (
    .Clk(clk), .Reset(rst), .bus(if2)
  );

  always #5 clk = ~clk;

  function automatic out_t ID(input int l);
    return '{1'b0, 3'(l), 1'b0, 1'b0, 1'b0, 1'b0};
  endfunction
  function automatic out_t SP(input int l);
    return '{1'b0, 3'(l), 1'b0, 1'b1, 1'b1, 1'b1};
  endfunction
  function automatic out_t IV(input int l, input logic v);
    return '{1'b0, 3'(l), 1'b0, 1'b0, 1'b1, v};
  endfunction
  function automatic out_t AL(input int l);
    return '{1'b0, 3'(l), 1'b0, 1'b0, 1'b0, 1'b1};
  endfunction
  function automatic out_t DY(input int l);
    return '{1'b0, 3'(l), 1'b1, 1'b0, 1'b0, 1'b1};
  endfunction
  function automatic out_t DD(input int l);
    return '{1'b1, 3'(l), 1'b0, 1'b0, 1'b0, 1'b0};
  endfunction

  function automatic out_t act1();
    return '{if1.playerDead, if1.lives, if1.dying, if1.respawn,
             if1.invulnerable, if1.playerVisible};
  endfunction
  function automatic out_t act2();
    return '{if2.playerDead, if2.lives, if2.dying, if2.respawn,
             if2.invulnerable, if2.playerVisible};
  endfunction

  task automatic add(input logic [1:0] g, input logic t, input logic h, input out_t e);
    vec_t v;
    v.gs = g; v.tick = t; v.hit = h; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input out_t a, input out_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got {dead,lives[3],dying,respawn,inv,vis}=%b expected %b (t=%0t)",
               name, a, e, $time);
    end
  endtask

  // Drive one cycle of inputs, queue expected outputs, sample #1 after the edge.
  task automatic cyc(input string name, input logic [1:0] g, input logic t, input logic h,
                     input logic c1, input out_t x1, input logic c2, input out_t x2);
    out_t e;
    gs = g; tick = t; hit = h;
    if (c1) q1.push_back(x1);
    if (c2) q2.push_back(x2);
    @(posedge clk);
    #1;
    if (c1) begin
      e = q1.pop_front();
      check({name, "/dut1"}, act1(), e);
    end
    if (c2) begin
      e = q2.pop_front();
      check({name, "/dut2"}, act2(), e);
    end
  endtask

  initial begin
    // Start of play and invulnerability window (hits ignored)
    add(2'b01, 1'b0, 1'b0, SP(2));
    add(2'b01, 1'b0, 1'b0, IV(2, 1'b1));
    add(2'b01, 1'b1, 1'b1, IV(2, 1'b1));
    add(2'b01, 1'b0, 1'b0, IV(2, 1'b1));
    add(2'b01, 1'b1, 1'b0, IV(2, 1'b1));
    add(2'b01, 1'b1, 1'b0, IV(2, 1'b1));
    add(2'b01, 1'b0, 1'b1, IV(2, 1'b1));
    add(2'b01, 1'b1, 1'b0, AL(2));
    add(2'b01, 1'b0, 1'b0, AL(2));
    // First hit, hits during DYING ignored, respawn after 3 ticks
    add(2'b01, 1'b0, 1'b1, DY(1));
    add(2'b01, 1'b0, 1'b1, DY(1));
    add(2'b01, 1'b1, 1'b0, DY(1));
    add(2'b01, 1'b1, 1'b1, DY(1));
    add(2'b01, 1'b1, 1'b0, SP(1));
    add(2'b01, 1'b0, 1'b0, IV(1, 1'b1));
    add(2'b01, 1'b1, 1'b0, IV(1, 1'b1));
    add(2'b01, 1'b1, 1'b0, IV(1, 1'b1));
    add(2'b01, 1'b1, 1'b0, IV(1, 1'b1));
    // hit on INVULN expiry is ignored
    add(2'b01, 1'b1, 1'b1, AL(1));
    // hit together with tick in ALIVE is taken
    add(2'b01, 1'b1, 1'b1, DY(0));
    add(2'b01, 1'b1, 1'b0, DY(0));
    add(2'b01, 1'b1, 1'b0, DY(0));
    add(2'b01, 1'b1, 1'b0, DD(0));
    add(2'b01, 1'b0, 1'b0, DD(0));
    add(2'b01, 1'b1, 1'b1, DD(0));
    // Game Over handshake
    add(2'b10, 1'b0, 1'b0, ID(0));
    add(2'b10, 1'b0, 1'b0, ID(0));
    // Re-enter play, abort from DYING, gameState 11, hit with not-Play
    add(2'b01, 1'b0, 1'b0, SP(2));
    add(2'b01, 1'b0, 1'b0, IV(2, 1'b1));
    add(2'b01, 1'b1, 1'b0, IV(2, 1'b1));
    add(2'b01, 1'b1, 1'b0, IV(2, 1'b1));
    add(2'b01, 1'b1, 1'b0, IV(2, 1'b1));
    add(2'b01, 1'b1, 1'b0, AL(2));
    add(2'b01, 1'b0, 1'b1, DY(1));
    add(2'b01, 1'b1, 1'b0, DY(1));
    add(2'b00, 1'b0, 1'b0, ID(1));
    add(2'b01, 1'b0, 1'b0, SP(2));
    add(2'b01, 1'b0, 1'b0, IV(2, 1'b1));
    add(2'b11, 1'b0, 1'b0, ID(2));
    add(2'b01, 1'b0, 1'b0, SP(2));
    add(2'b01, 1'b0, 1'b0, IV(2, 1'b1));
    add(2'b01, 1'b1, 1'b0, IV(2, 1'b1));
    add(2'b01, 1'b1, 1'b0, IV(2, 1'b1));
    add(2'b01, 1'b1, 1'b0, IV(2, 1'b1));
    add(2'b01, 1'b1, 1'b0, AL(2));
    add(2'b00, 1'b1, 1'b1, ID(2));
    add(2'b00, 1'b0, 1'b0, ID(2));

    // Reset state on both instances
    rst = 1'b1;
    cyc("reset", 2'b00, 1'b0, 1'b0, 1'b1, ID(0), 1'b1, ID(0));
    rst = 1'b0;

    foreach (tbl[i]) begin
      cyc($sformatf("vec%0d", i), tbl[i].gs, tbl[i].tick, tbl[i].hit,
          1'b1, tbl[i].exp, 1'b0, ID(0));
    end

    // Blink pattern on the 16-frame instance
    rst = 1'b1;
    cyc("reset2", 2'b00, 1'b0, 1'b0, 1'b1, ID(0), 1'b1, ID(0));
    rst = 1'b0;
    cyc("blink_spawn", 2'b01, 1'b0, 1'b0, 1'b0, ID(0), 1'b1, SP(2));
    cyc("blink_0", 2'b01, 1'b0, 1'b0, 1'b0, ID(0), 1'b1, IV(2, 1'b1));
    for (int i = 0; i < 16; i++) begin
      out_t x;
      if (i == 15) x = AL(2);
      else         x = IV(2, (((i + 1) % 8) < 4) ? 1'b1 : 1'b0);
      cyc($sformatf("blink_tick%0d", i + 1), 2'b01, 1'b1, 1'b0, 1'b0, ID(0), 1'b1, x);
    end

    // Reset in the middle of INVULN
    cyc("mid_leave", 2'b00, 1'b0, 1'b0, 1'b1, ID(2), 1'b1, ID(2));
    cyc("mid_spawn", 2'b01, 1'b0, 1'b0, 1'b1, SP(2), 1'b1, SP(2));
    cyc("mid_inv", 2'b01, 1'b0, 1'b0, 1'b1, IV(2, 1'b1), 1'b1, IV(2, 1'b1));
    cyc("mid_tick", 2'b01, 1'b1, 1'b0, 1'b1, IV(2, 1'b1), 1'b1, IV(2, 1'b1));
    rst = 1'b1;
    cyc("mid_reset", 2'b01, 1'b1, 1'b1, 1'b1, ID(0), 1'b1, ID(0));
    rst = 1'b0;
    cyc("post_reset", 2'b01, 1'b0, 1'b0, 1'b1, SP(2), 1'b1, SP(2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
